// File: rtl/ysyx_041514_icache_axi_rd.sv
// ysyx_041514_icache_axi_rd
//
// Read-only responder for the icache refill port. It turns each held-valid
// icache burst request into one AXI4 INCR read, and returns every R beat to
// the icache as a one-cycle data pulse.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   ram_raddr/valid/rmask/rsize/rlen_icache_i   icache request (valid held for the burst)
//   ram_rdata_ready_icache_o       one-cycle beat-valid pulse
//   ram_rdata_icache_o             raw 64-bit beat data
//   bus_err_o                      one-cycle error pulse
//   axi_ar_*                       AXI read address channel
//   axi_r_*                        AXI read data channel
module ysyx_041514_icache_axi_rd #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64,
    parameter logic [3:0]  AR_ID  = 4'd0
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic [ADDR_W-1:0] ram_raddr_icache_i,
    input  logic              ram_raddr_valid_icache_i,
    input  logic [7:0]        ram_rmask_icache_i,
    input  logic [3:0]        ram_rsize_icache_i,
    input  logic [7:0]        ram_rlen_icache_i,
    output logic              ram_rdata_ready_icache_o,
    output logic [DATA_W-1:0] ram_rdata_icache_o,
    output logic              bus_err_o,

    output logic              axi_ar_valid_o,
    input  logic              axi_ar_ready_i,
    output logic [ADDR_W-1:0] axi_ar_addr_o,
    output logic [3:0]        axi_ar_id_o,
    output logic [7:0]        axi_ar_len_o,
    output logic [2:0]        axi_ar_size_o,
    output logic [1:0]        axi_ar_burst_o,

    input  logic              axi_r_valid_i,
    output logic              axi_r_ready_o,
    input  logic [DATA_W-1:0] axi_r_data_i,
    input  logic [1:0]        axi_r_resp_i,
    input  logic              axi_r_last_i
);

    typedef enum logic [1:0] {StIdle, StAr, StR, StWaitLow} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ar_addr_q, ar_addr_d;
    logic [7:0]          ar_len_q, ar_len_d;
    logic [2:0]          ar_size_q, ar_size_d;
    logic [7:0]          beat_cnt_q, beat_cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rdata_ready_q, rdata_ready_d;
    logic                bus_err_q, bus_err_d;

    logic [2:0]          size_enc;
    logic                size_bad;
    logic                beat_err;

    // The mask is always full today; kept on the port for the icache's benefit.
    logic unused_rmask;
    assign unused_rmask = ^ram_rmask_icache_i;

    always_comb begin
        size_bad = 1'b0;
        case (ram_rsize_icache_i)
            4'd1:    size_enc = 3'd0;
            4'd2:    size_enc = 3'd1;
            4'd4:    size_enc = 3'd2;
            4'd8:    size_enc = 3'd3;
            default: begin
                size_enc = 3'd3;
                size_bad = 1'b1;
            end
        endcase
    end

    // Bad response, early/late r_last relative to the requested length.
    assign beat_err = (axi_r_resp_i != 2'b00)
                    || (axi_r_last_i && (beat_cnt_q != ar_len_q))
                    || (!axi_r_last_i && (beat_cnt_q == ar_len_q));

    always_comb begin
        state_d       = state_q;
        ar_addr_d     = ar_addr_q;
        ar_len_d      = ar_len_q;
        ar_size_d     = ar_size_q;
        beat_cnt_d    = beat_cnt_q;
        rdata_d       = rdata_q;
        rdata_ready_d = 1'b0;
        bus_err_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ram_raddr_valid_icache_i) begin
                    ar_addr_d  = ram_raddr_icache_i;
                    ar_len_d   = ram_rlen_icache_i;
                    ar_size_d  = size_enc;
                    beat_cnt_d = 8'd0;
                    bus_err_d  = size_bad;
                    state_d    = StAr;
                end
            end
            StAr: begin
                if (axi_ar_ready_i) begin
                    beat_cnt_d = 8'd0;
                    state_d    = StR;
                end
            end
            StR: begin
                if (axi_r_valid_i) begin
                    rdata_d       = axi_r_data_i;
                    rdata_ready_d = 1'b1;
                    bus_err_d     = beat_err;
                    if (beat_cnt_q != 8'hff) begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                    if (axi_r_last_i) begin
                        state_d = StWaitLow;
                    end
                end
            end
            StWaitLow: begin
                // Valid of the finished request is still high; wait for it to drop.
                if (!ram_raddr_valid_icache_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            ar_addr_q     <= '0;
            ar_len_q      <= '0;
            ar_size_q     <= '0;
            beat_cnt_q    <= '0;
            rdata_q       <= '0;
            rdata_ready_q <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ar_addr_q     <= ar_addr_d;
            ar_len_q      <= ar_len_d;
            ar_size_q     <= ar_size_d;
            beat_cnt_q    <= beat_cnt_d;
            rdata_q       <= rdata_d;
            rdata_ready_q <= rdata_ready_d;
            bus_err_q     <= bus_err_d;
        end
    end

    assign axi_ar_valid_o           = (state_q == StAr);
    assign axi_ar_addr_o            = ar_addr_q;
    assign axi_ar_id_o              = AR_ID;
    assign axi_ar_len_o             = ar_len_q;
    assign axi_ar_size_o            = ar_size_q;
    assign axi_ar_burst_o           = 2'b01;
    assign axi_r_ready_o            = (state_q == StR);
    assign ram_rdata_ready_icache_o = rdata_ready_q;
    assign ram_rdata_icache_o       = rdata_q;
    assign bus_err_o                = bus_err_q;

endmodule
